// File: rtl/word_16to8_serializer_if.sv
// ============================================================================
//  Module      : word_16to8_serializer_if
//  Description : Bundles the word input strobe, the byte valid/ready stream
//                and the FIFO status outputs of word_16to8_serializer.
//                master = the environment (drives words and ready_in),
//                slave  = the serializer.
//  Signals     : valid_in, data_in[15:0]   word strobe from upstream
//                ready_in                  downstream byte acceptance
//                valid_out, data_out[7:0]  byte stream
//                level[$clog2(DEPTH):0]    words held in the FIFO
//                overflow                  sticky word-dropped flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface word_16to8_serializer_if #(
    parameter int DEPTH = 4
) ();
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               valid_in;
    logic [15:0]        data_in;
    logic               ready_in;
    logic               valid_out;
    logic [7:0]         data_out;
    logic [LEVEL_W-1:0] level;
    logic               overflow;

    modport master (
        output valid_in, data_in, ready_in,
        input  valid_out, data_out, level, overflow
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output valid_out, data_out, level, overflow
    );
endinterface

`default_nettype wire

// File: rtl/word_16to8_serializer.sv
// ============================================================================
//  Module      : word_16to8_serializer
//  Description : Buffers 16-bit word strobes in a DEPTH-entry FIFO and
//                re-emits each word as two bytes on a valid/ready stream.
//                Words arriving while the FIFO is full (and not popping on
//                the same edge) are dropped and set a sticky overflow flag.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous, active-high reset
//                bus  - slave modport: valid_in/data_in in, ready_in in,
//                       valid_out/data_out out, level out, overflow out
//  Parameters  : DEPTH     - FIFO entries, power of two, >= 2
//                MSB_FIRST - 1: data_in[15:8] first, 0: data_in[7:0] first
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_16to8_serializer #(
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  wire                     clk,
    input  wire                     rst,
    word_16to8_serializer_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [15:0]        word_q, word_d;
    logic               overflow_q, overflow_d;

    logic               w_pop;
    logic               w_push;
    logic               w_not_empty;
    logic               w_full;
    logic [7:0]         w_first_byte;
    logic [7:0]         w_second_byte;

    assign w_not_empty = (level_q != '0);
    assign w_full      = (level_q == LEVEL_W'(DEPTH));

    // The output stage pulls a new word when it is empty, or on the edge the
    // second byte leaves, so consecutive words stream without a bubble.
    assign w_pop  = w_not_empty &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_SECOND) && bus.ready_in));

    // A full FIFO still accepts a word when its head leaves on the same edge.
    assign w_push = bus.valid_in && (!w_full || w_pop);

    assign w_first_byte  = (MSB_FIRST != 0) ? word_q[15:8] : word_q[7:0];
    assign w_second_byte = (MSB_FIRST != 0) ? word_q[7:0]  : word_q[15:8];

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        level_d    = level_q + LEVEL_W'(w_push) - LEVEL_W'(w_pop);

        if (w_push) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (bus.valid_in && !w_push) begin
            overflow_d = 1'b1;
        end

        if (w_pop) begin
            word_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (w_pop) state_d = ST_FIRST;
            end
            ST_FIRST: begin
                if (bus.ready_in) state_d = ST_SECOND;
            end
            ST_SECOND: begin
                if (bus.ready_in) state_d = w_pop ? ST_FIRST : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decode registered state only; ready_in and valid_in never
    // reach them combinationally. data_out is zero while no byte is offered.
    always_comb begin
        bus.valid_out = (state_q == ST_FIRST) || (state_q == ST_SECOND);
        bus.data_out  = 8'h00;
        if (state_q == ST_FIRST)  bus.data_out = w_first_byte;
        if (state_q == ST_SECOND) bus.data_out = w_second_byte;
    end

    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_word_16to8_serializer.sv
// ============================================================================
//  Module      : tb_word_16to8_serializer
//  Description : Directed self-checking bench for word_16to8_serializer.
//                u_dut_msb uses MSB_FIRST=1, u_dut_lsb uses MSB_FIRST=0;
//                both have DEPTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word_16to8_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    word_16to8_serializer_if #(.DEPTH(4)) bus_m ();
    word_16to8_serializer_if #(.DEPTH(4)) bus_l ();

    word_16to8_serializer #(.DEPTH(4), .MSB_FIRST(1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    word_16to8_serializer #(.DEPTH(4), .MSB_FIRST(0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    // Advance one edge; inputs written after this are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus_m.valid_in = 1'b0; bus_m.data_in = '0; bus_m.ready_in = 1'b0;
        bus_l.valid_in = 1'b0; bus_l.data_in = '0; bus_l.ready_in = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [7:0] exp_bytes [10];

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid", 16'(bus_m.valid_out), 16'h1 & 16'h0);
        chk("rst_data",  16'(bus_m.data_out),  16'h00);
        chk("rst_level", 16'(bus_m.level),     16'h0);
        chk("rst_ovf",   16'(bus_m.overflow),  16'h0);

        // ---------------- 1: single word, 2-cycle latency ----------------
        bus_m.ready_in = 1'b1;
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'hA55A;
        step();
        bus_m.valid_in = 1'b0;
        chk("t1_lat_valid", 16'(bus_m.valid_out), 16'h0);
        chk("t1_lat_level", 16'(bus_m.level),     16'h1);
        step();
        chk("t1_b0_valid", 16'(bus_m.valid_out), 16'h1);
        chk("t1_b0_data",  16'(bus_m.data_out),  16'hA5);
        chk("t1_b0_level", 16'(bus_m.level),     16'h0);
        step();
        chk("t1_b1_valid", 16'(bus_m.valid_out), 16'h1);
        chk("t1_b1_data",  16'(bus_m.data_out),  16'h5A);
        step();
        chk("t1_end_valid", 16'(bus_m.valid_out), 16'h0);
        chk("t1_end_level", 16'(bus_m.level),     16'h0);

        // ---------------- 2: word every 2 cycles, no bubbles ----------------
        for (int i = 0; i <= 8; i++) begin
            bus_m.valid_in = (i < 8) && (i % 2 == 0);
            bus_m.data_in  = 16'h1234;
            step();
            if (i >= 1) begin
                chk("t2_valid", 16'(bus_m.valid_out), 16'h1);
                chk("t2_data",  16'(bus_m.data_out), (i % 2 == 1) ? 16'h12 : 16'h34);
            end
            chk("t2_level_le1", 16'(bus_m.level <= 3'd1), 16'h1);
        end
        bus_m.valid_in = 1'b0;
        step();
        chk("t2_end_valid", 16'(bus_m.valid_out), 16'h0);
        chk("t2_ovf",       16'(bus_m.overflow),  16'h0);

        // ---------------- 3: backpressure, fill and overflow ----------------
        do_reset();
        bus_m.ready_in = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            bus_m.valid_in = 1'b1;
            bus_m.data_in  = {8'(w), 8'(w)};
            step();
        end
        bus_m.valid_in = 1'b0;
        chk("t3_level3", 16'(bus_m.level),     16'h3);
        chk("t3_valid",  16'(bus_m.valid_out), 16'h1);
        chk("t3_data",   16'(bus_m.data_out),  16'h01);
        step();
        chk("t3_hold_data", 16'(bus_m.data_out), 16'h01);
        chk("t3_hold_lvl",  16'(bus_m.level),    16'h3);
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'h0505;
        step();
        chk("t3_level4", 16'(bus_m.level),    16'h4);
        chk("t3_no_ovf", 16'(bus_m.overflow), 16'h0);
        bus_m.data_in = 16'h0606;
        step();
        bus_m.valid_in = 1'b0;
        chk("t3_drop_lvl", 16'(bus_m.level),    16'h4);
        chk("t3_ovf",      16'(bus_m.overflow), 16'h1);
        chk("t3_stall_data", 16'(bus_m.data_out), 16'h01);
        exp_bytes = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05};
        bus_m.ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_drain_valid", 16'(bus_m.valid_out), 16'h1);
            chk("t3_drain_data",  16'(bus_m.data_out),  16'(exp_bytes[i]));
            step();
        end
        chk("t3_end_valid", 16'(bus_m.valid_out), 16'h0);
        chk("t3_end_level", 16'(bus_m.level),     16'h0);
        chk("t3_ovf_sticky", 16'(bus_m.overflow), 16'h1);

        // ---------------- 4: full FIFO with simultaneous pop ----------------
        do_reset();
        bus_m.ready_in = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            bus_m.valid_in = 1'b1;
            bus_m.data_in  = {8'(w * 17), 8'(w * 17)};
            step();
        end
        bus_m.valid_in = 1'b0;
        chk("t4_full", 16'(bus_m.level), 16'h4);
        bus_m.ready_in = 1'b1;
        step();
        chk("t4_second_data", 16'(bus_m.data_out), 16'h11);
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'h6666;
        step();
        bus_m.valid_in = 1'b0; bus_m.ready_in = 1'b0;
        chk("t4_level", 16'(bus_m.level),    16'h4);
        chk("t4_ovf",   16'(bus_m.overflow), 16'h0);
        chk("t4_next",  16'(bus_m.data_out), 16'h22);

        // ---------------- 5: LSB-first ordering ----------------
        bus_l.ready_in = 1'b1;
        bus_l.valid_in = 1'b1; bus_l.data_in = 16'hBEEF;
        step();
        bus_l.valid_in = 1'b0;
        chk("t5_lat_valid", 16'(bus_l.valid_out), 16'h0);
        step();
        chk("t5_b0", 16'(bus_l.data_out), 16'hEF);
        step();
        chk("t5_b1", 16'(bus_l.data_out), 16'hBE);
        step();
        chk("t5_end_valid", 16'(bus_l.valid_out), 16'h0);

        // ---------------- 6: asynchronous reset mid-word ----------------
        do_reset();
        bus_m.ready_in = 1'b0;
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'h1122; step();
        bus_m.data_in = 16'h3344; step();
        bus_m.data_in = 16'h5566; step();
        bus_m.valid_in = 1'b0;
        bus_m.ready_in = 1'b1;
        step();
        bus_m.ready_in = 1'b0;
        chk("t6_second", 16'(bus_m.data_out), 16'h22);
        chk("t6_queued", 16'(bus_m.level),    16'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 16'(bus_m.valid_out), 16'h0);
        chk("t6_rst_level", 16'(bus_m.level),     16'h0);
        chk("t6_rst_ovf",   16'(bus_m.overflow),  16'h0);
        step();
        step();
        rst = 1'b0;
        bus_m.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_quiet_valid", 16'(bus_m.valid_out), 16'h0);
        end
        chk("t6_quiet_level", 16'(bus_m.level), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
